// File: rtl/axi4_lite_slave_write.sv
// AXI4-Lite slave write path: one-entry AW/W buffers, byte-strobed register write, B response.
// Define AXI_SLV_ADDR_CHECK_EN to answer out-of-range addresses with SLVERR and suppress the write.
module axi4_lite_slave_write #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 8,
  parameter  int NUM_REGS   = 16,
  localparam int IDX_W      = $clog2(NUM_REGS),
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_W-1:0]     WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  reg_wr_en,
  output logic [IDX_W-1:0]      reg_idx,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_W-1:0]     reg_wstrb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                  aw_full;
  logic                  w_full;
  logic                  aw_full_nxt;
  logic                  w_full_nxt;
  logic                  aw_rdy;
  logic                  w_rdy;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  do_write;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  unused_ok;

  assign AWREADY = aw_rdy;
  assign WREADY  = w_rdy;
  assign aw_hs   = AWVALID && aw_rdy;
  assign w_hs    = WVALID && w_rdy;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (aw_full && w_full) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (BREADY) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    do_write = 1'b0;
    BVALID   = 1'b0;
    unique case (state)
      S_WRITE: do_write = 1'b1;
      S_RESP:  BVALID   = 1'b1;
      default: ;
    endcase
  end

  // READY mirrors the next-cycle empty flag so it stays registered
  always_comb begin
    aw_full_nxt = aw_full && !do_write;
    w_full_nxt  = w_full && !do_write;
    if (aw_hs) aw_full_nxt = 1'b1;
    if (w_hs)  w_full_nxt  = 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_rdy   <= 1'b0;
      w_rdy    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      aw_full <= aw_full_nxt;
      w_full  <= w_full_nxt;
      aw_rdy  <= !aw_full_nxt;
      w_rdy   <= !w_full_nxt;
      if (aw_hs) awaddr_q <= AWADDR;
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
    end
  end

`ifdef AXI_SLV_ADDR_CHECK_EN
  assign addr_err =
    awaddr_q[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(NUM_REGS);
`else
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      reg_wr_en <= 1'b0;
      reg_idx   <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      BRESP     <= 2'b00;
    end else begin
      reg_wr_en <= do_write && !addr_err;
      if (do_write) begin
        reg_idx   <= awaddr_q[IDX_W+1:2];
        reg_wdata <= wdata_q;
        reg_wstrb <= wstrb_q;
        BRESP     <= addr_err ? 2'b10 : 2'b00;
      end
    end
  end

  assign unused_ok = ^{AWPROT, awaddr_q};

endmodule
